// File: rtl/ex_ctrl_pkg.sv
// rtl/ex_ctrl_pkg.sv - shared types and constants for the execute-unit issue arbiter
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } ex_state_t;

    localparam int FLAG_OVF  = 0;
    localparam int FLAG_ZERO = 1;
    localparam int FLAG_COND = 2;
    localparam int FLAG_ERR  = 3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 8;
    localparam int DEFAULT_OP_W           = 5;

    // Flags reported when an operation is abandoned: error only.
    localparam logic [3:0] TIMEOUT_FLAGS = 4'(1 << FLAG_ERR);

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter, combinational grant, registered pointer
module rr_arbiter2 (
    input  logic soc_clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1,
    output logic gnt_id
);

    logic ptr;

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        gnt0   = req0 && (!req1 || !ptr);
        gnt1   = req1 && (!req0 || ptr);
        gnt_id = gnt1;
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~gnt_id;
        end
    end

endmodule

// File: rtl/ex_issue_arbiter.sv
// rtl/ex_issue_arbiter.sv - shares the execute ALU between two requesters with timeout and response channel
module ex_issue_arbiter
    import ex_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int OP_W           = DEFAULT_OP_W
) (
    input  logic            soc_clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_rs1,
    input  logic [31:0]     req0_rs2,
    input  logic [31:0]     req0_imm,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_rs1,
    input  logic [31:0]     req1_rs2,
    input  logic [31:0]     req1_imm,
    input  logic [OP_W-1:0] req1_op,
    output logic            ex_reset,
    output logic [31:0]     ex_rs1,
    output logic [31:0]     ex_rs2,
    output logic [31:0]     ex_imm,
    output logic [OP_W-1:0] ex_op,
    input  logic [31:0]     ex_result,
    input  logic            ex_result_ready,
    input  logic [3:0]      ex_flags,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [31:0]     rsp_data,
    output logic [3:0]      rsp_flags,
    output logic            rsp_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    ex_state_t        state;
    ex_state_t        state_nxt;
    logic [CNT_W-1:0] run_cnt;
    logic             in_idle;
    logic             accept;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_id;
    logic             run_expire;

    assign in_idle    = (state == IDLE) && !reset;
    assign accept     = in_idle && (req0_valid || req1_valid);
    assign req0_ready = in_idle && gnt0;
    assign req1_ready = in_idle && gnt1;
    assign run_expire = (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    rr_arbiter2 u_arb (
        .soc_clk (soc_clk),
        .reset   (reset),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .accept  (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id)
    );

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ex_reset  = 1'b1;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = RUN;
            end
            RUN: begin
                ex_reset = 1'b0;
                if (ex_result_ready || run_expire) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_imm      <= '0;
            ex_op       <= '0;
            rsp_id      <= 1'b0;
            run_cnt     <= '0;
            rsp_data    <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                ex_rs1 <= gnt_id ? req1_rs1 : req0_rs1;
                ex_rs2 <= gnt_id ? req1_rs2 : req0_rs2;
                ex_imm <= gnt_id ? req1_imm : req0_imm;
                ex_op  <= gnt_id ? req1_op  : req0_op;
                rsp_id <= gnt_id;
            end

            if (state == LAUNCH) begin
                run_cnt <= '0;
            end else if (state == RUN) begin
                run_cnt <= run_cnt + 1'b1;
            end

            // A result arriving on the last allowed cycle beats the timeout.
            if (state == RUN) begin
                if (ex_result_ready) begin
                    rsp_data    <= ex_result;
                    rsp_flags   <= ex_flags;
                    rsp_timeout <= 1'b0;
                end else if (run_expire) begin
                    rsp_data    <= '0;
                    rsp_flags   <= TIMEOUT_FLAGS;
                    rsp_timeout <= 1'b1;
                end
            end
        end
    end

endmodule
